llc_set_writeback: RTL and testbench

Write-back engine for the LLC set buffers. It tracks which ways of the currently buffered set the LLC controller has modified, and also whether the evict way has changed. On command it writes each modified way back into localmem, one way per accepted write, in ascending way order. It then writes the evict way if needed and pulses done. It sits between the LLC controller and localmem as the write-side counterpart of the set-buffer read path.

---
 rtl/llc_set_writeback.sv | 137 +++++++++++++
 tb/tb_llc_set_writeback.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/llc_set_writeback.sv
// rtl/llc_set_writeback.sv - write-back engine for modified ways of the buffered LLC set
module llc_set_writeback #(
  parameter int WAYS      = 16,
  parameter int WAY_W     = 4,
  parameter int SET_W     = 9,
  parameter int LINE_W    = 128,
  parameter int TAG_W     = 15,
  parameter int SHARERS_W = 16,
  parameter int OWNER_W   = 4,
  parameter int HPROT_W   = 1,
  parameter int STATE_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_set_into_bufs,
  input  logic                 upd_valid,
  input  logic [WAY_W-1:0]     upd_way,
  input  logic                 upd_evict_way,
  input  logic                 wb_start,
  input  logic [SET_W-1:0]     wb_set,
  output logic                 wb_busy,
  output logic                 wb_done,
  input  logic [LINE_W-1:0]    lines_buf      [WAYS],
  input  logic [TAG_W-1:0]     tags_buf       [WAYS],
  input  logic [SHARERS_W-1:0] sharers_buf    [WAYS],
  input  logic [OWNER_W-1:0]   owners_buf     [WAYS],
  input  logic [HPROT_W-1:0]   hprots_buf     [WAYS],
  input  logic [STATE_W-1:0]   states_buf     [WAYS],
  input  logic                 dirty_bits_buf [WAYS],
  input  logic [WAY_W-1:0]     evict_way_buf,
  output logic                 lmem_wr_en,
  output logic                 lmem_wr_evict_en,
  input  logic                 lmem_wr_ready,
  output logic [SET_W-1:0]     lmem_wr_set,
  output logic [WAY_W-1:0]     lmem_wr_way,
  output logic [LINE_W-1:0]    lmem_wr_data_line,
  output logic [TAG_W-1:0]     lmem_wr_data_tag,
  output logic [SHARERS_W-1:0] lmem_wr_data_sharers,
  output logic [OWNER_W-1:0]   lmem_wr_data_owner,
  output logic [HPROT_W-1:0]   lmem_wr_data_hprot,
  output logic [STATE_W-1:0]   lmem_wr_data_state,
  output logic                 lmem_wr_data_dirty_bit,
  output logic [WAY_W-1:0]     lmem_wr_data_evict_way
);

  typedef enum logic [1:0] {IDLE, WR_WAY, WR_EVICT, DONE} state_t;

  state_t            state, state_d;
  logic [WAYS-1:0]   pend_mask, pend_d, rem;
  logic              evict_pend, evict_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic [WAY_W-1:0]  cur_way, cur_d;

  function automatic logic [WAY_W-1:0] lowest(input logic [WAYS-1:0] m);
    lowest = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (m[i]) lowest = WAY_W'(i);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pend_mask  <= '0;
      evict_pend <= 1'b0;
      set_q      <= '0;
      cur_way    <= '0;
    end else begin
      state      <= state_d;
      pend_mask  <= pend_d;
      evict_pend <= evict_d;
      set_q      <= set_d;
      cur_way    <= cur_d;
    end
  end

  always_comb begin
    state_d = state;
    pend_d  = pend_mask;
    evict_d = evict_pend;
    set_d   = set_q;
    cur_d   = cur_way;
    rem     = pend_mask & ~(WAYS'(1) << cur_way);
    case (state)
      IDLE: begin
        // A start snapshots the current marks; same-cycle marks would race the snapshot
        if (wb_start) begin
          set_d = wb_set;
          if (pend_mask != '0) begin
            cur_d   = lowest(pend_mask);
            state_d = WR_WAY;
          end else if (evict_pend) begin
            state_d = WR_EVICT;
          end else begin
            state_d = DONE;
          end
        end else if (rd_set_into_bufs) begin
          pend_d  = '0;
          evict_d = 1'b0;
        end else begin
          if (upd_valid)     pend_d[upd_way] = 1'b1;
          if (upd_evict_way) evict_d = 1'b1;
        end
      end
      WR_WAY: begin
        if (lmem_wr_ready) begin
          pend_d = rem;
          if (rem != '0) cur_d = lowest(rem);
          else           state_d = evict_pend ? WR_EVICT : DONE;
        end
      end
      WR_EVICT: begin
        if (lmem_wr_ready) begin
          evict_d = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_busy          = (state != IDLE);
  assign wb_done          = (state == DONE);
  assign lmem_wr_en       = (state == WR_WAY);
  assign lmem_wr_evict_en = (state == WR_EVICT);
  assign lmem_wr_set      = set_q;
  assign lmem_wr_way      = cur_way;

  assign lmem_wr_data_line      = lines_buf[cur_way];
  assign lmem_wr_data_tag       = tags_buf[cur_way];
  assign lmem_wr_data_sharers   = sharers_buf[cur_way];
  assign lmem_wr_data_owner     = owners_buf[cur_way];
  assign lmem_wr_data_hprot     = hprots_buf[cur_way];
  assign lmem_wr_data_state     = states_buf[cur_way];
  assign lmem_wr_data_dirty_bit = dirty_bits_buf[cur_way];
  assign lmem_wr_data_evict_way = lmem_wr_evict_en ? evict_way_buf : '0;

endmodule

// File: tb/tb_llc_set_writeback.sv
// tb/tb_llc_set_writeback.sv - directed self-checking bench for llc_set_writeback
module tb_llc_set_writeback;
  localparam int WAYS = 16, WAY_W = 4, SET_W = 9;

  logic clk = 1'b0;
  logic rst;
  logic rd_set_into_bufs, upd_valid, upd_evict_way, wb_start;
  logic [WAY_W-1:0] upd_way;
  logic [SET_W-1:0] wb_set;
  logic wb_busy, wb_done;
  logic [127:0] lines_buf [WAYS];
  logic [14:0]  tags_buf [WAYS];
  logic [15:0]  sharers_buf [WAYS];
  logic [3:0]   owners_buf [WAYS];
  logic [0:0]   hprots_buf [WAYS];
  logic [2:0]   states_buf [WAYS];
  logic         dirty_bits_buf [WAYS];
  logic [WAY_W-1:0] evict_way_buf;
  logic lmem_wr_en, lmem_wr_evict_en, lmem_wr_ready;
  logic [SET_W-1:0] lmem_wr_set;
  logic [WAY_W-1:0] lmem_wr_way, lmem_wr_data_evict_way;
  logic [127:0] lmem_wr_data_line;
  logic [14:0]  lmem_wr_data_tag;
  logic [15:0]  lmem_wr_data_sharers;
  logic [3:0]   lmem_wr_data_owner;
  logic [0:0]   lmem_wr_data_hprot;
  logic [2:0]   lmem_wr_data_state;
  logic         lmem_wr_data_dirty_bit;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  llc_set_writeback dut (
    .clk(clk), .rst(rst), .rd_set_into_bufs(rd_set_into_bufs),
    .upd_valid(upd_valid), .upd_way(upd_way), .upd_evict_way(upd_evict_way),
    .wb_start(wb_start), .wb_set(wb_set), .wb_busy(wb_busy), .wb_done(wb_done),
    .lines_buf(lines_buf), .tags_buf(tags_buf), .sharers_buf(sharers_buf),
    .owners_buf(owners_buf), .hprots_buf(hprots_buf), .states_buf(states_buf),
    .dirty_bits_buf(dirty_bits_buf), .evict_way_buf(evict_way_buf),
    .lmem_wr_en(lmem_wr_en), .lmem_wr_evict_en(lmem_wr_evict_en),
    .lmem_wr_ready(lmem_wr_ready), .lmem_wr_set(lmem_wr_set), .lmem_wr_way(lmem_wr_way),
    .lmem_wr_data_line(lmem_wr_data_line), .lmem_wr_data_tag(lmem_wr_data_tag),
    .lmem_wr_data_sharers(lmem_wr_data_sharers), .lmem_wr_data_owner(lmem_wr_data_owner),
    .lmem_wr_data_hprot(lmem_wr_data_hprot), .lmem_wr_data_state(lmem_wr_data_state),
    .lmem_wr_data_dirty_bit(lmem_wr_data_dirty_bit),
    .lmem_wr_data_evict_way(lmem_wr_data_evict_way)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_way(input string tag, input int w, input logic [SET_W-1:0] s);
    chk({tag, ".en"}, 128'(lmem_wr_en), 128'd1);
    chk({tag, ".evict_en"}, 128'(lmem_wr_evict_en), 128'd0);
    chk({tag, ".way"}, 128'(lmem_wr_way), 128'(w));
    chk({tag, ".set"}, 128'(lmem_wr_set), 128'(s));
    chk({tag, ".line"}, lmem_wr_data_line, 128'h1234_0000_0000_0000_0000 + 128'(w * 257));
    chk({tag, ".tag"}, 128'(lmem_wr_data_tag), 128'(w * 7 + 1));
    chk({tag, ".sharers"}, 128'(lmem_wr_data_sharers), 128'(32'd1 << w));
    chk({tag, ".owner"}, 128'(lmem_wr_data_owner), 128'(15 - w));
    chk({tag, ".hprot"}, 128'(lmem_wr_data_hprot), 128'(w % 2));
    chk({tag, ".state"}, 128'(lmem_wr_data_state), 128'(w % 8));
    chk({tag, ".dirty"}, 128'(lmem_wr_data_dirty_bit), 128'((w / 2) % 2));
  endtask

  task automatic mark(input int w);
    upd_valid = 1'b1;
    upd_way = WAY_W'(w);
    tick();
    upd_valid = 1'b0;
  endtask

  initial begin
    int exp_ways [3];
    exp_ways = '{0, 3, 9};
    for (int i = 0; i < WAYS; i++) begin
      lines_buf[i]      = 128'h1234_0000_0000_0000_0000 + 128'(i * 257);
      tags_buf[i]       = 15'(i * 7 + 1);
      sharers_buf[i]    = 16'(32'd1 << i);
      owners_buf[i]     = 4'(15 - i);
      hprots_buf[i]     = 1'(i % 2);
      states_buf[i]     = 3'(i % 8);
      dirty_bits_buf[i] = 1'((i / 2) % 2);
    end
    evict_way_buf = 4'd7;
    rst = 1'b1; rd_set_into_bufs = 0; upd_valid = 0; upd_way = 0; upd_evict_way = 0;
    wb_start = 0; wb_set = 0; lmem_wr_ready = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst.busy", 128'(wb_busy), 0);
    chk("rst.done", 128'(wb_done), 0);
    chk("rst.en", 128'(lmem_wr_en), 0);
    chk("rst.evict_en", 128'(lmem_wr_evict_en), 0);
    chk("rst.set", 128'(lmem_wr_set), 0);
    chk("rst.way", 128'(lmem_wr_way), 0);
    chk("rst.evict_way", 128'(lmem_wr_data_evict_way), 0);

    // three ways, ready tied high
    mark(3); mark(0); mark(9);
    wb_start = 1; wb_set = 9'h1A5; lmem_wr_ready = 1;
    tick();
    wb_start = 0;
    chk("t1.busy", 128'(wb_busy), 1);
    for (int k = 0; k < 3; k++) begin
      chk_way($sformatf("t1.w%0d", exp_ways[k]), exp_ways[k], 9'h1A5);
      chk("t1.nodone", 128'(wb_done), 0);
      tick();
    end
    chk("t1.done", 128'(wb_done), 1);
    chk("t1.done_en", 128'(lmem_wr_en), 0);
    tick();
    chk("t1.idle_busy", 128'(wb_busy), 0);
    chk("t1.idle_done", 128'(wb_done), 0);

    // one way plus evict, ready stalled for 3 cycles
    upd_valid = 1; upd_way = 4'd5; upd_evict_way = 1;
    tick();
    upd_valid = 0; upd_evict_way = 0;
    wb_start = 1; wb_set = 9'h0F0; lmem_wr_ready = 0;
    tick();
    wb_start = 0;
    for (int k = 0; k < 3; k++) begin
      chk_way($sformatf("t2.stall%0d", k), 5, 9'h0F0);
      tick();
    end
    chk_way("t2.stall3", 5, 9'h0F0);
    lmem_wr_ready = 1;
    tick();
    chk("t2.ev_en", 128'(lmem_wr_evict_en), 1);
    chk("t2.ev_wen", 128'(lmem_wr_en), 0);
    chk("t2.ev_way", 128'(lmem_wr_data_evict_way), 7);
    chk("t2.ev_set", 128'(lmem_wr_set), 9'h0F0);
    tick();
    chk("t2.done", 128'(wb_done), 1);
    chk("t2.done_ev", 128'(lmem_wr_evict_en), 0);
    tick();
    chk("t2.idle", 128'(wb_busy), 0);

    // nothing marked
    wb_start = 1; wb_set = 9'h033;
    tick();
    wb_start = 0;
    chk("t3.done", 128'(wb_done), 1);
    chk("t3.en", 128'(lmem_wr_en), 0);
    chk("t3.ev", 128'(lmem_wr_evict_en), 0);
    tick();
    chk("t3.idle_done", 128'(wb_done), 0);
    chk("t3.idle_busy", 128'(wb_busy), 0);

    // clear wins over same-cycle mark
    mark(1); mark(2);
    rd_set_into_bufs = 1; upd_valid = 1; upd_way = 4'd4;
    tick();
    rd_set_into_bufs = 0; upd_valid = 0;
    wb_start = 1;
    tick();
    wb_start = 0;
    chk("t4.done", 128'(wb_done), 1);
    chk("t4.en", 128'(lmem_wr_en), 0);
    tick();

    // all ways marked, reset after 5 accepted writes
    for (int i = 0; i < WAYS; i++) mark(i);
    wb_start = 1; wb_set = 9'h155; lmem_wr_ready = 1;
    tick();
    wb_start = 0;
    for (int k = 0; k < 5; k++) tick();
    chk_way("t5.w5", 5, 9'h155);
    rst = 1;
    #1;
    chk("t5.busy", 128'(wb_busy), 0);
    chk("t5.done", 128'(wb_done), 0);
    chk("t5.en", 128'(lmem_wr_en), 0);
    chk("t5.set", 128'(lmem_wr_set), 0);
    chk("t5.way", 128'(lmem_wr_way), 0);
    tick(); tick();
    chk("t5.nodone", 128'(wb_done), 0);
    rst = 0;
    tick();
    wb_start = 1;
    tick();
    wb_start = 0;
    chk("t5.post_done", 128'(wb_done), 1);
    chk("t5.post_en", 128'(lmem_wr_en), 0);
    tick();

    // start and mark while busy are ignored
    mark(2); mark(6);
    wb_start = 1; wb_set = 9'h0AA; lmem_wr_ready = 0;
    tick();
    chk_way("t6.w2", 2, 9'h0AA);
    wb_set = 9'h011; upd_valid = 1; upd_way = 4'd0;
    tick();
    wb_start = 0; upd_valid = 0;
    chk_way("t6.w2hold", 2, 9'h0AA);
    lmem_wr_ready = 1;
    tick();
    chk_way("t6.w6", 6, 9'h0AA);
    tick();
    chk("t6.done", 128'(wb_done), 1);
    tick();
    chk("t6.idle", 128'(wb_busy), 0);
    wb_start = 1;
    tick();
    wb_start = 0;
    chk("t6.empty_done", 128'(wb_done), 1);
    chk("t6.empty_en", 128'(lmem_wr_en), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
